// File: rtl/motion_pkg.sv
// Shared types and helpers for the streaming motion detector.
// Output modes plus a width-agnostic absolute difference.
package motion_pkg;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,
        MODE_MASK      = 2'd1,
        MODE_HIGHLIGHT = 2'd2,
        MODE_DIFF      = 2'd3
    } mode_t;

    localparam int ABS_W = 32;

    function automatic logic [ABS_W-1:0] abs_diff(
        input logic [ABS_W-1:0] a,
        input logic [ABS_W-1:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/motion_rgb_to_gray.sv
// Combinational gray conversion: floor of the channel mean.
// Channel 0 sits in the least significant bits.
module motion_rgb_to_gray #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int NUM_CHANNELS  = 3
) (
    input  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0] pixel,
    output logic [CHANNEL_WIDTH-1:0]              gray
);

    localparam int SUM_WIDTH = CHANNEL_WIDTH + $clog2(NUM_CHANNELS);

    logic [SUM_WIDTH-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sum = sum + SUM_WIDTH'(pixel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
        end
    end

    assign gray = CHANNEL_WIDTH'(sum / SUM_WIDTH'(NUM_CHANNELS));

endmodule

// File: rtl/motion_detect_core.sv
// Three-stage streaming motion detector between two input FIFOs and an
// output FIFO, with per-frame motion statistics.
module motion_detect_core
    import motion_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int NUM_CHANNELS  = 3,
    parameter int FRAME_PIXELS  = 307200,
    parameter logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0] HIGHLIGHT_COLOR =
        (CHANNEL_WIDTH*NUM_CHANNELS)'(24'hFF0000),
    localparam int DATA_WIDTH = CHANNEL_WIDTH * NUM_CHANNELS,
    localparam int CNT_WIDTH  = $clog2(FRAME_PIXELS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    bg_dout,
    input  logic                     bg_empty,
    output logic                     bg_rd_en,
    input  logic [DATA_WIDTH-1:0]    fr_dout,
    input  logic                     fr_empty,
    output logic                     fr_rd_en,
    input  logic                     out_full,
    output logic                     out_wr_en,
    output logic [DATA_WIDTH-1:0]    out_din,
    input  logic [CHANNEL_WIDTH-1:0] threshold,
    input  logic [1:0]               mode,
    output logic [CNT_WIDTH-1:0]     motion_count,
    output logic                     frame_done
);

    logic [CHANNEL_WIDTH-1:0] gray_bg;
    logic [CHANNEL_WIDTH-1:0] gray_fr;

    logic                     s1_valid_q, s1_valid_d;
    logic [CHANNEL_WIDTH-1:0] s1_gray_bg_q, s1_gray_bg_d;
    logic [CHANNEL_WIDTH-1:0] s1_gray_fr_q, s1_gray_fr_d;
    logic [DATA_WIDTH-1:0]    s1_pix_q, s1_pix_d;
    mode_t                    s1_mode_q, s1_mode_d;
    logic [CHANNEL_WIDTH-1:0] s1_thr_q, s1_thr_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [CHANNEL_WIDTH-1:0] s2_diff_q, s2_diff_d;
    logic                     s2_motion_q, s2_motion_d;
    logic [DATA_WIDTH-1:0]    s2_pix_q, s2_pix_d;
    mode_t                    s2_mode_q, s2_mode_d;

    logic                     s3_valid_q, s3_valid_d;
    logic                     s3_motion_q, s3_motion_d;
    logic [DATA_WIDTH-1:0]    out_din_q, out_din_d;

    logic [CNT_WIDTH-1:0]     pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_WIDTH-1:0]     motion_count_q, motion_count_d;

    logic                     advance;
    logic                     pop;
    logic                     wr;
    logic                     last_pix;
    logic [DATA_WIDTH-1:0]    s3_pix;

    motion_rgb_to_gray #(
        .CHANNEL_WIDTH(CHANNEL_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_gray_bg (
        .pixel(bg_dout),
        .gray (gray_bg)
    );

    motion_rgb_to_gray #(
        .CHANNEL_WIDTH(CHANNEL_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_gray_fr (
        .pixel(fr_dout),
        .gray (gray_fr)
    );

    // The whole pipeline moves as one; a full output FIFO freezes every stage.
    assign advance   = !s3_valid_q || !out_full;
    assign pop       = !bg_empty && !fr_empty && advance && reset;
    assign wr        = s3_valid_q && !out_full;
    assign last_pix  = pix_cnt_q == CNT_WIDTH'(FRAME_PIXELS - 1);

    assign bg_rd_en     = pop;
    assign fr_rd_en     = pop;
    assign out_wr_en    = wr;
    assign out_din      = out_din_q;
    assign motion_count = motion_count_q;
    assign frame_done   = wr && last_pix;

    always_comb begin
        s3_pix = s2_pix_q;
        unique case (s2_mode_q)
            MODE_PASS:      s3_pix = s2_pix_q;
            MODE_MASK:      s3_pix = s2_motion_q ? '1 : '0;
            MODE_HIGHLIGHT: s3_pix = s2_motion_q ? HIGHLIGHT_COLOR : s2_pix_q;
            MODE_DIFF:      s3_pix = {NUM_CHANNELS{s2_diff_q}};
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_gray_bg_d = s1_gray_bg_q;
        s1_gray_fr_d = s1_gray_fr_q;
        s1_pix_d     = s1_pix_q;
        s1_mode_d    = s1_mode_q;
        s1_thr_d     = s1_thr_q;
        s2_valid_d   = s2_valid_q;
        s2_diff_d    = s2_diff_q;
        s2_motion_d  = s2_motion_q;
        s2_pix_d     = s2_pix_q;
        s2_mode_d    = s2_mode_q;
        s3_valid_d   = s3_valid_q;
        s3_motion_d  = s3_motion_q;
        out_din_d    = out_din_q;
        if (advance) begin
            s1_valid_d   = pop;
            s1_gray_bg_d = gray_bg;
            s1_gray_fr_d = gray_fr;
            s1_pix_d     = fr_dout;
            s1_mode_d    = mode_t'(mode);
            s1_thr_d     = threshold;
            s2_valid_d   = s1_valid_q;
            s2_diff_d    = CHANNEL_WIDTH'(abs_diff(ABS_W'(s1_gray_fr_q),
                                                   ABS_W'(s1_gray_bg_q)));
            s2_motion_d  = s2_diff_d > s1_thr_q;
            s2_pix_d     = s1_pix_q;
            s2_mode_d    = s1_mode_q;
            s3_valid_d   = s2_valid_q;
            s3_motion_d  = s2_motion_q;
            out_din_d    = s3_pix;
        end
    end

    // Frame statistics follow writes, so stalls never skew the count.
    always_comb begin
        pix_cnt_d      = pix_cnt_q;
        acc_d          = acc_q;
        motion_count_d = motion_count_q;
        if (wr) begin
            if (last_pix) begin
                motion_count_d = acc_q + CNT_WIDTH'(s3_motion_q);
                pix_cnt_d      = '0;
                acc_d          = '0;
            end else begin
                pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
                acc_d     = acc_q + CNT_WIDTH'(s3_motion_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q     <= 1'b0;
            s1_gray_bg_q   <= '0;
            s1_gray_fr_q   <= '0;
            s1_pix_q       <= '0;
            s1_mode_q      <= MODE_PASS;
            s1_thr_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_diff_q      <= '0;
            s2_motion_q    <= 1'b0;
            s2_pix_q       <= '0;
            s2_mode_q      <= MODE_PASS;
            s3_valid_q     <= 1'b0;
            s3_motion_q    <= 1'b0;
            out_din_q      <= '0;
            pix_cnt_q      <= '0;
            acc_q          <= '0;
            motion_count_q <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_gray_bg_q   <= s1_gray_bg_d;
            s1_gray_fr_q   <= s1_gray_fr_d;
            s1_pix_q       <= s1_pix_d;
            s1_mode_q      <= s1_mode_d;
            s1_thr_q       <= s1_thr_d;
            s2_valid_q     <= s2_valid_d;
            s2_diff_q      <= s2_diff_d;
            s2_motion_q    <= s2_motion_d;
            s2_pix_q       <= s2_pix_d;
            s2_mode_q      <= s2_mode_d;
            s3_valid_q     <= s3_valid_d;
            s3_motion_q    <= s3_motion_d;
            out_din_q      <= out_din_d;
            pix_cnt_q      <= pix_cnt_d;
            acc_q          <= acc_d;
            motion_count_q <= motion_count_d;
        end
    end

endmodule

// File: tb/tb_motion_detect_core.sv
// Randomised and directed bench for motion_detect_core (4-pixel frames).
// FIFOs are modelled as queues; expectations come from a channel-mean model.
module tb_motion_detect_core;

    localparam int FP = 4;

    logic        clock;
    logic        reset;
    logic [23:0] bg_dout;
    logic        bg_empty;
    logic        bg_rd_en;
    logic [23:0] fr_dout;
    logic        fr_empty;
    logic        fr_rd_en;
    logic        out_full;
    logic        out_wr_en;
    logic [23:0] out_din;
    logic [7:0]  threshold;
    logic [1:0]  mode;
    logic [2:0]  motion_count;
    logic        frame_done;

    logic [23:0] bgq[$];
    logic [23:0] frq[$];
    logic [23:0] exp_px[$];
    bit          exp_mot[$];
    logic [23:0] obs_q[$];
    bit          fd_q[$];
    logic [2:0]  mc_q[$];
    int          pop_cyc[$];
    int          wr_cyc[$];
    int          cyc;
    bit          last_pop;
    bit          last_fpop;
    int          n_tests;
    int          n_fail;

    motion_detect_core #(
        .FRAME_PIXELS(FP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bg_dout     (bg_dout),
        .bg_empty    (bg_empty),
        .bg_rd_en    (bg_rd_en),
        .fr_dout     (fr_dout),
        .fr_empty    (fr_empty),
        .fr_rd_en    (fr_rd_en),
        .out_full    (out_full),
        .out_wr_en   (out_wr_en),
        .out_din     (out_din),
        .threshold   (threshold),
        .mode        (mode),
        .motion_count(motion_count),
        .frame_done  (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int gray_of(input logic [23:0] p);
        int s;
        s = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]);
        return s / 3;
    endfunction

    function automatic int gdiff(input logic [23:0] b, input logic [23:0] f);
        int gb;
        int gf;
        gb = gray_of(b);
        gf = gray_of(f);
        return (gf > gb) ? gf - gb : gb - gf;
    endfunction

    function automatic logic [24:0] model(input logic [23:0] b,
                                          input logic [23:0] f,
                                          input logic [1:0]  m,
                                          input logic [7:0]  t);
        int          d;
        bit          mot;
        logic [23:0] px;
        logic [7:0]  d8;
        d   = gdiff(b, f);
        mot = d > int'(t);
        d8  = d[7:0];
        case (m)
            2'd0:    px = f;
            2'd1:    px = mot ? 24'hFFFFFF : 24'h000000;
            2'd2:    px = mot ? 24'hFF0000 : f;
            default: px = {d8, d8, d8};
        endcase
        return {mot, px};
    endfunction

    // One clock: present FIFO heads, sample mid-low-phase, then step a cycle.
    task automatic tick();
        logic [24:0] r;
        bg_empty = (bgq.size() == 0);
        fr_empty = (frq.size() == 0);
        bg_dout  = bg_empty ? 24'h0 : bgq[0];
        fr_dout  = fr_empty ? 24'h0 : frq[0];
        #1;
        last_pop  = bg_rd_en;
        last_fpop = fr_rd_en;
        if (bg_rd_en && fr_rd_en && !bg_empty && !fr_empty) begin
            r = model(bgq[0], frq[0], mode, threshold);
            exp_px.push_back(r[23:0]);
            exp_mot.push_back(r[24]);
            pop_cyc.push_back(cyc);
        end
        if (bg_rd_en && !bg_empty) void'(bgq.pop_front());
        if (fr_rd_en && !fr_empty) void'(frq.pop_front());
        if (out_wr_en) begin
            obs_q.push_back(out_din);
            fd_q.push_back(frame_done);
            mc_q.push_back(motion_count);
            wr_cyc.push_back(cyc);
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic clear_logs();
        exp_px.delete();
        exp_mot.delete();
        obs_q.delete();
        fd_q.delete();
        mc_q.delete();
        pop_cyc.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        out_full  = 1'b0;
        mode      = 2'd0;
        threshold = 8'd0;
        bgq.delete();
        frq.delete();
        tick();
        tick();
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bgq.push_back(24'h123456);
        frq.push_back(24'h654321);
        tick();
        tick();
        n_tests++;
        if (bg_rd_en !== 1'b0 || fr_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pop: rd_en=%b/%b required 0/0", bg_rd_en, fr_rd_en);
        end
        n_tests++;
        if (out_wr_en !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr: wr=%b fd=%b required 0 0", out_wr_en, frame_done);
        end
        n_tests++;
        if (out_din !== 24'h0 || motion_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_val: din=%h mc=%0d required 0 0", out_din, motion_count);
        end
        do_reset();
    endtask

    task automatic test_directed();
        logic [23:0] want[4];
        want[0] = 24'hFF0000;
        want[1] = 24'h404040;
        want[2] = 24'h303030;
        want[3] = 24'h000000;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            threshold = (k == 0) ? 8'd32 : 8'd48;
            mode = (k < 2) ? 2'd2 : ((k == 2) ? 2'd3 : 2'd1);
            bgq.push_back(24'h101010);
            frq.push_back(24'h404040);
            for (int c = 0; c < 6; c++) tick();
        end
        n_tests++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL directed_count: got %0d writes required 4", obs_q.size());
        end
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== want[k]) begin
                n_fail++;
                $display("FAIL directed_px%0d: got %h required %h", k, obs_q[k], want[k]);
            end
        end
        if (wr_cyc.size() > 0 && pop_cyc.size() > 0) begin
            n_tests++;
            if (wr_cyc[0] - pop_cyc[0] != 3) begin
                n_fail++;
                $display("FAIL latency: got %0d required 3", wr_cyc[0] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int stall_pops;
        do_reset();
        stall_pops = 0;
        for (int k = 0; k < 10; k++) begin
            bgq.push_back(24'($urandom));
            frq.push_back(24'($urandom));
        end
        for (int c = 0; c < 25; c++) begin
            mode      = 2'($urandom_range(0, 3));
            threshold = 8'($urandom_range(0, 80));
            out_full  = (c >= 5 && c < 10);
            tick();
            if (out_full && last_pop) stall_pops++;
        end
        n_tests++;
        if (stall_pops != 0) begin
            n_fail++;
            $display("FAIL stall_pop: got %0d pops required 0", stall_pops);
        end
        n_tests++;
        if (obs_q.size() != 10 || exp_px.size() != 10) begin
            n_fail++;
            $display("FAIL bp_count: got %0d/%0d required 10", obs_q.size(), exp_px.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_px.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_px[i]) begin
                n_fail++;
                $display("FAIL bp_px%0d: got %h required %h", i, obs_q[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        bgq.push_back(24'h0A0B0C);
        tick();
        n_tests++;
        if (last_pop !== 1'b0 || last_fpop !== 1'b0) begin
            n_fail++;
            $display("FAIL one_empty: rd_en=%b/%b required 0/0", last_pop, last_fpop);
        end
        frq.push_back(24'h0C0B0A);
        tick();
        n_tests++;
        if (last_pop !== 1'b1 || last_fpop !== 1'b1) begin
            n_fail++;
            $display("FAIL both_pop: rd_en=%b/%b required 1/1", last_pop, last_fpop);
        end
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_stats();
        bit pat[8];
        pat = '{1, 0, 1, 1, 0, 0, 0, 0};
        do_reset();
        mode      = 2'd1;
        threshold = 8'd32;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                bgq.push_back(24'h101010);
                frq.push_back(pat[f*4+k] ? 24'h404040 : 24'h101010);
            end
            for (int c = 0; c < 10; c++) tick();
            n_tests++;
            if (fd_q.size() != 4*(f+1) || fd_q[4*f+3] !== 1'b1
                || fd_q[4*f] || fd_q[4*f+1] || fd_q[4*f+2]) begin
                n_fail++;
                $display("FAIL frame_done%0d: writes=%0d required pulse on 4th", f, fd_q.size());
            end
            n_tests++;
            if (motion_count !== ((f == 0) ? 3'd3 : 3'd0)) begin
                n_fail++;
                $display("FAIL motion_count%0d: got %0d required %0d", f, motion_count,
                         (f == 0) ? 3 : 0);
            end
        end
    endtask

    task automatic test_midreset();
        int n;
        do_reset();
        mode      = 2'd1;
        threshold = 8'd10;
        for (int k = 0; k < 4; k++) begin
            bgq.push_back(24'h000000);
            frq.push_back(24'hFFFFFF);
        end
        for (int c = 0; c < 10; c++) tick();
        n_tests++;
        if (motion_count !== 3'd4) begin
            n_fail++;
            $display("FAIL pre_reset_mc: got %0d required 4", motion_count);
        end
        bgq.push_back(24'h000000);
        frq.push_back(24'hFFFFFF);
        bgq.push_back(24'h000000);
        frq.push_back(24'hFFFFFF);
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (out_wr_en !== 1'b0 || motion_count !== 3'd0 || out_din !== 24'h0) begin
            n_fail++;
            $display("FAIL mid_reset: wr=%b mc=%0d din=%h required 0 0 0",
                     out_wr_en, motion_count, out_din);
        end
        reset = 1'b1;
        n = obs_q.size();
        for (int c = 0; c < 8; c++) tick();
        n_tests++;
        if (obs_q.size() != n) begin
            n_fail++;
            $display("FAIL stale_out: got %0d writes required 0", obs_q.size() - n);
        end
    endtask

    task automatic test_random();
        int nb;
        int nf;
        int f;
        int s;
        do_reset();
        nb = 0;
        nf = 0;
        for (int c = 0; c < 700; c++) begin
            if (nb < 200 && $urandom_range(0, 3) != 0) begin
                bgq.push_back(24'($urandom));
                nb++;
            end
            if (nf < 200 && $urandom_range(0, 3) != 0) begin
                frq.push_back(24'($urandom));
                nf++;
            end
            mode      = 2'($urandom_range(0, 3));
            threshold = 8'($urandom_range(0, 255));
            if (bgq.size() > 0 && frq.size() > 0 && $urandom_range(0, 2) == 0)
                threshold = 8'(gdiff(bgq[0], frq[0]) - int'($urandom_range(0, 1)));
            out_full = (c < 650) && ($urandom_range(0, 3) == 0);
            tick();
        end
        n_tests++;
        if (obs_q.size() != 200 || exp_px.size() != 200) begin
            n_fail++;
            $display("FAIL rand_count: got %0d/%0d required 200", obs_q.size(), exp_px.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_px.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_px[i]) begin
                n_fail++;
                $display("FAIL rand_px%0d: got %h required %h", i, obs_q[i], exp_px[i]);
            end
            n_tests++;
            if (fd_q[i] !== ((i % FP) == FP - 1)) begin
                n_fail++;
                $display("FAIL rand_fd%0d: got %b required %b", i, fd_q[i], (i % FP) == FP - 1);
            end
            f = i / FP;
            s = 0;
            if (f > 0)
                for (int k = (f-1)*FP; k < f*FP; k++) s += int'(exp_mot[k]);
            n_tests++;
            if (int'(mc_q[i]) != s) begin
                n_fail++;
                $display("FAIL rand_mc%0d: got %0d required %0d", i, mc_q[i], s);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        reset     = 1'b0;
        out_full  = 1'b0;
        mode      = 2'd0;
        threshold = 8'd0;
        bg_empty  = 1'b1;
        fr_empty  = 1'b1;
        bg_dout   = 24'h0;
        fr_dout   = 24'h0;
        test_reset();
        test_directed();
        test_backpressure();
        test_empty();
        test_stats();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
